// File: rtl/fc_sequencer.sv
// fc_sequencer: runs one fully-connected classification pass per ECG window.
// It streams NUM_BEATS 4-lane feature words from the feature buffer into the
// FC datapath and waits for the datapath's done flag. The captured class is
// then offered downstream on a valid/ready handshake.
//
// Optional feature: define FC_SEQ_STATS_EN to add saturating normal/abnormal
// result counters (cnt_normal, cnt_abnormal). The ports are absent otherwise.
//
// Handshake: res_valid rises in RESULT and stays high with res_class/res_err
// stable until a cycle where res_valid && res_ready, which is the transfer.
// res_valid never depends combinationally on res_ready.
module fc_sequencer #(
  parameter int NUM_BEATS = 16,
  parameter int ADDR_W    = 4,
  parameter int WAIT_MAX  = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              buf_rd,
  output logic [ADDR_W-1:0] buf_addr,
  input  logic [31:0]       buf_rdata,
  output logic              fc_en,
  output logic [31:0]       fc_in,
  input  logic              fc_flag,
  input  logic [1:0]        fc_class,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [1:0]        res_class,
  output logic              res_err,
`ifdef FC_SEQ_STATS_EN
  output logic [15:0]       cnt_normal,
  output logic [15:0]       cnt_abnormal,
`endif
  output logic [2:0]        dbg_state
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_PRIME  = 3'd1;
  localparam logic [2:0] S_STREAM = 3'd2;
  localparam logic [2:0] S_WAIT   = 3'd3;
  localparam logic [2:0] S_RESULT = 3'd4;

  localparam int WAIT_W = (WAIT_MAX < 2) ? 1 : $clog2(WAIT_MAX + 1);

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] beat_q, beat_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [1:0]        res_class_q, res_class_d;
  logic              res_err_q, res_err_d;

  logic              last_beat;
  logic [ADDR_W-1:0] beat_inc;
  logic [WAIT_W-1:0] wait_inc;

  assign last_beat = (beat_q == ADDR_W'(NUM_BEATS - 1));
  assign beat_inc  = beat_q + 1'b1;
  assign wait_inc  = wait_q + 1'b1;

  // Next-state logic: pass sequencing, class capture and timeout.
  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    wait_d      = wait_q;
    res_class_d = res_class_q;
    res_err_d   = res_err_q;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_PRIME;
      end
      S_PRIME: begin
        beat_d  = '0;
        state_d = S_STREAM;
      end
      S_STREAM: begin
        if (last_beat) begin
          wait_d  = '0;
          state_d = S_WAIT;
        end else begin
          beat_d = beat_inc;
        end
      end
      S_WAIT: begin
        if (fc_flag) begin
          res_class_d = fc_class;
          res_err_d   = 1'b0;
          state_d     = S_RESULT;
        end else begin
          wait_d = wait_inc;
          if (wait_inc == WAIT_W'(WAIT_MAX)) begin
            // Datapath never finished: report an error class instead.
            res_class_d = 2'b11;
            res_err_d   = 1'b1;
            state_d     = S_RESULT;
          end
        end
      end
      S_RESULT: begin
        // A start seen here is dropped; only IDLE samples start.
        if (res_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and capture registers; reset abandons any pass in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      beat_q      <= '0;
      wait_q      <= '0;
      res_class_q <= 2'b00;
      res_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      wait_q      <= wait_d;
      res_class_q <= res_class_d;
      res_err_q   <= res_err_d;
    end
  end

  // Outputs decoded from state. The read for beat b+1 is issued during
  // beat b so that the 1-cycle buffer latency lines the data up.
  always_comb begin
    busy      = (state_q != S_IDLE);
    buf_rd    = 1'b0;
    buf_addr  = '0;
    fc_en     = 1'b0;
    fc_in     = 32'd0;
    res_valid = 1'b0;
    case (state_q)
      S_PRIME: begin
        buf_rd = 1'b1;
      end
      S_STREAM: begin
        fc_en = 1'b1;
        fc_in = buf_rdata;
        if (!last_beat) begin
          buf_rd   = 1'b1;
          buf_addr = beat_inc;
        end
      end
      S_WAIT: begin
        // Enable stays high so the datapath keeps its accumulated sum.
        fc_en = 1'b1;
      end
      S_RESULT: begin
        // Enable low here is what clears the datapath for the next pass.
        res_valid = 1'b1;
      end
      default: ;
    endcase
  end

  assign res_class = res_class_q;
  assign res_err   = res_err_q;
  assign dbg_state = state_q;

`ifdef FC_SEQ_STATS_EN
  logic [15:0] cnt_normal_q, cnt_abnormal_q;
  logic        res_xfer;

  assign res_xfer = res_valid && res_ready && !res_err_q;

  // Saturating counters of delivered results; timeouts are not counted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_normal_q   <= 16'd0;
      cnt_abnormal_q <= 16'd0;
    end else if (res_xfer) begin
      if (res_class_q == 2'b00) begin
        if (cnt_normal_q != 16'hFFFF) cnt_normal_q <= cnt_normal_q + 16'd1;
      end else begin
        if (cnt_abnormal_q != 16'hFFFF) cnt_abnormal_q <= cnt_abnormal_q + 16'd1;
      end
    end
  end

  assign cnt_normal   = cnt_normal_q;
  assign cnt_abnormal = cnt_abnormal_q;
`endif

endmodule
